// File: rtl/timer_share_pkg.sv
// Shared types and constants for the two-requester timer controller.
package timer_share_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [N_REQ-1:0] GRANT_NONE = 2'b00;
    localparam logic [N_REQ-1:0] GRANT_0    = 2'b01;
    localparam logic [N_REQ-1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational round-robin pick between two requesters.
module rr_arbiter2
    import timer_share_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic [N_REQ-1:0] win
);

    // last holds the index of the previous owner; on contention the other side wins
    always_comb begin
        win = GRANT_NONE;
        case (req)
            2'b01:   win = GRANT_0;
            2'b10:   win = GRANT_1;
            2'b11:   win = last ? GRANT_0 : GRANT_1;
            default: win = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/timer_share_ctrl.sv
// Shares one down-counting timer between two requesters with round-robin
// arbitration, terminal-count done pulse and release handshake.
module timer_share_ctrl
    import timer_share_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] load_val0,
    input  logic [WIDTH-1:0] load_val1,
    input  logic             tick,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic [N_REQ-1:0] done
);

    state_t           state;
    logic             last;
    logic [N_REQ-1:0] win;
    logic             owner_req;

    rr_arbiter2 u_arb (
        .req  (req),
        .last (last),
        .win  (win)
    );

    assign owner_req = (req & grant) != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            done  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state <= COUNT;
                        grant <= win;
                        busy  <= 1'b1;
                        cnt   <= win[0] ? load_val0 : load_val1;
                        last  <= win[1];
                    end
                end
                COUNT: begin
                    // abort outranks a terminal tick in the same cycle
                    if (!owner_req) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == '0) begin
                            done  <= grant;
                            state <= RELEASE;
                        end else begin
                            cnt <= cnt - WIDTH'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (!owner_req) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_share_ctrl.md
# timer_share_ctrl

Controller that shares one synchronous down-counting timer between two requesters. It arbitrates round-robin, loads the winner's start value, and decrements on each `tick`. It pulses `done` to the owner at terminal count and releases the timer once the owner drops its request. It sits between the sequential-logic counter datapath and client FSMs that need timed delays.

## Interface
- `WIDTH`, default 3: counter width in bits.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester level request; held until `done` is seen or the requester aborts.
- `load_val0`  in  WIDTH  start value for requester 0; sampled on grant.
- `load_val1`  in  WIDTH  start value for requester 1; sampled on grant.
- `tick`  in  1  count enable, one-cycle strobe (prescaler output).
- `grant`  out  2  one-hot owner; 0 when idle.
- `busy`  out  1  high in COUNT and RELEASE.
- `cnt`  out  WIDTH  current counter value.
- `done`  out  2  one-cycle pulse to the owner at terminal count.

## Operation
- All outputs are registered. Reset values: `grant`=0, `busy`=0, `cnt`=0, `done`=0, state IDLE, last-owner pointer=1 (requester 0 wins first).
- States:
  - IDLE -> COUNT when `req`≠0.
  - COUNT -> RELEASE on terminal count.
  - COUNT -> IDLE on abort.
  - RELEASE -> IDLE when the owner's `req` is low.
- IDLE, one request: grant that requester.
- IDLE, both requests: grant the one that is not the last owner, then update the pointer. Load `cnt` with the winner's `load_val`.
- COUNT, `tick`=1 and `cnt`>0: `cnt` decrements by 1.
- COUNT, `tick`=1 and `cnt`=0: `done[owner]`=1 for one cycle and go to RELEASE. `cnt` stays 0. No wrap to all-ones.
- COUNT, `tick`=0: `cnt` holds.
- Abort: the owner's `req` is low while in COUNT. Go to IDLE, clear `grant` and `busy`, set `cnt`=0, no `done`. Abort takes priority over a simultaneous terminal `tick`.
- RELEASE: `grant` and `busy` stay high and `cnt`=0. Exit when the owner's `req` is low. The other requester's `req` is ignored until IDLE.
- A non-owner's `req` is never granted mid-operation. No preemption.
- `load_val*` are sampled only on the grant edge. Later changes are ignored.
- `load_val`=0 is legal: `done` on the first `tick`.

## Timing
- Grant latency: `req` high before edge k gives `grant`, `busy`, `cnt`=load all valid after edge k.
- A `tick` coincident with the grant edge is not counted.
- Duration: `done` follows the (load+1)-th counted `tick`. It is asserted after the edge that samples that tick.
- Re-grant: at least 1 IDLE cycle between owners. Back-to-back service is RELEASE -> IDLE -> COUNT.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The pointer also resets.

## Structure
- Package `timer_share_pkg`: state enum (IDLE, COUNT, RELEASE), `N_REQ`=2, one-hot grant constants.
- Sub-module `rr_arbiter2`: combinational round-robin pick from `req` plus the last-owner pointer, producing a one-hot winner.
- Counter and FSM live in the top module.

## Test plan
- Reset with `req`=2'b11: after release, `grant`=01 on the first edge and `cnt`=`load_val0`.
- `load_val0`=5, `tick` every cycle: `cnt` goes 5,4,3,2,1,0, then `done`=01 after the 6th tick. Holding `req` keeps state RELEASE and `cnt`=0.
- Both requesting continuously: grants alternate 01,10,01 with one IDLE cycle between owners.
- `tick` every third cycle, `load_val1`=2: `done`=10 after exactly 3 ticks, and `cnt` holds between ticks.
- Abort: drop `req[0]` at `cnt`=3. Next edge gives `grant`=0 and `cnt`=0 with no `done`. A pending `req[1]` is then granted.
- `load_val0`=0 with a tick: `done` one cycle after the grant, with no underflow to 7. Assert `rst` low during COUNT: all outputs 0 immediately.
